// File: rtl/wait_state_gen_if.sv
// Bus-side signals of the wait-state generator: CPU access qualifiers,
// per-source ready/enable inputs and the synchronised ready/watchdog outputs.
interface wait_state_gen_if #(
   parameter int unsigned NUM_SRC = 3
);
   logic               INTA_N;
   logic               IO_OR_M;
   logic               IO_E;
   logic [NUM_SRC-1:0] SRC_READY;
   logic [NUM_SRC-1:0] SRC_MASK;
   logic               RDY;
   logic               TIMEOUT_ERR;

   // CPU / bus side drives the access and the ready sources
   modport master (
      output INTA_N, IO_OR_M, IO_E, SRC_READY, SRC_MASK,
      input  RDY, TIMEOUT_ERR
   );

   // Wait-state generator side
   modport slave (
      input  INTA_N, IO_OR_M, IO_E, SRC_READY, SRC_MASK,
      output RDY, TIMEOUT_ERR
   );
endinterface

// File: rtl/wait_state_gen.sv
// Wait-state generator: inserts minimum I/O / memory wait states, then holds the
// CPU until all enabled ready sources agree. Optional watchdog: WAIT_STATE_TIMEOUT_EN.
module wait_state_gen #(
   parameter int unsigned NUM_SRC  = 3,
   parameter int unsigned IO_WAIT  = 1,
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cpu_clock_posedge,
   input  logic             cpu_clock_negedge,
   wait_state_gen_if.slave  bus
);
   localparam int unsigned WAIT_W = 4;
   localparam int unsigned WD_W   = 16;

   localparam logic [WAIT_W-1:0] IO_LOAD  = WAIT_W'(IO_WAIT);
   localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(MEM_WAIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_HOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              q_q, q_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;

   logic [NUM_SRC-1:0] src_ok_c;
   logic               rdy_all_c;
   logic               d_cur_c;
   logic [WAIT_W-1:0]  load_c;

`ifdef WAIT_STATE_TIMEOUT_EN
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
   logic [WD_W-1:0] wd_q, wd_d;
`else
   logic [WD_W-1:0] unused_timeout_c;
   assign unused_timeout_c = WD_W'(TIMEOUT);
`endif

   // Masked-off sources always count as ready; an empty mask is ready
   assign src_ok_c  = bus.SRC_READY | ~bus.SRC_MASK;
   assign rdy_all_c = &src_ok_c;

   function automatic logic ready_term(input state_e st, input logic rdy_all,
                                       input logic inta_n);
      return (st == S_IDLE) || (st == S_DONE) ||
             ((st == S_HOLD) && rdy_all) || !inta_n;
   endfunction

   assign d_cur_c = ready_term(state_q, rdy_all_c, bus.INTA_N);
   assign load_c  = bus.IO_OR_M ? IO_LOAD : MEM_LOAD;

   // Next-state: posedge strobe advances FSM/Q, negedge strobe then sees the result
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rdy_d   = rdy_q;
`ifdef WAIT_STATE_TIMEOUT_EN
      wd_d    = wd_q;
      err_d   = err_q;
`endif

      if (cpu_clock_posedge) begin
         q_d = d_cur_c;
         if (!bus.IO_E) begin
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef WAIT_STATE_TIMEOUT_EN
            wd_d    = '0;
            err_d   = 1'b0;
`endif
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  cnt_d   = load_c;
                  state_d = (load_c == '0) ? S_HOLD : S_COUNT;
               end
               S_COUNT: begin
                  cnt_d = cnt_q - WAIT_W'(1);
                  if (cnt_d == '0) begin
                     state_d = S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (rdy_all_c) begin
                     state_d = S_DONE;
                  end
               end
               S_DONE: begin
                  state_d = S_DONE;
               end
            endcase

`ifdef WAIT_STATE_TIMEOUT_EN
            // Watchdog saturates; on expiry release the CPU immediately
            if ((state_q == S_COUNT) || (state_q == S_HOLD)) begin
               wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
               if (wd_d >= WD_LIMIT) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  q_d     = 1'b1;
                  err_d   = 1'b1;
               end
            end
`endif
         end
      end

      if (cpu_clock_negedge) begin
         rdy_d = ready_term(state_d, rdy_all_c, bus.INTA_N) & q_d;
      end
   end

`ifndef WAIT_STATE_TIMEOUT_EN
   assign err_d = 1'b0;
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef WAIT_STATE_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rdy_q   <= rdy_d;
`ifdef WAIT_STATE_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.RDY         = rdy_q;
   assign bus.TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_wait_state_gen.sv
// Directed bench for wait_state_gen: one DUT with IO_WAIT=1, one with IO_WAIT=15.
module tb_wait_state_gen;
`ifdef WAIT_STATE_TIMEOUT_EN
   localparam logic EXP_TO = 1'b1;
`else
   localparam logic EXP_TO = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cpu_clock_posedge = 1'b0;
   logic cpu_clock_negedge = 1'b0;

   int checks = 0;
   int errors = 0;

   wait_state_gen_if #(.NUM_SRC(3)) bus   ();
   wait_state_gen_if #(.NUM_SRC(3)) bus15 ();

   wait_state_gen #(.NUM_SRC(3), .IO_WAIT(1), .MEM_WAIT(0), .TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
      .bus(bus)
   );

   wait_state_gen #(.NUM_SRC(3), .IO_WAIT(15), .MEM_WAIT(0), .TIMEOUT(255)) dut15 (
      .clock(clock), .reset(reset),
      .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
      .bus(bus15)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic p, input logic n);
      cpu_clock_posedge = p;
      cpu_clock_negedge = n;
      @(negedge clock);
      cpu_clock_posedge = 1'b0;
      cpu_clock_negedge = 1'b0;
   endtask

   task automatic cpu_pos();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic cpu_neg();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
   endtask

   task automatic drive(input logic io_e, input logic io_or_m, input logic inta_n,
                        input logic [2:0] ready, input logic [2:0] mask);
      bus.IO_E = io_e;        bus15.IO_E = io_e;
      bus.IO_OR_M = io_or_m;  bus15.IO_OR_M = io_or_m;
      bus.INTA_N = inta_n;    bus15.INTA_N = inta_n;
      bus.SRC_READY = ready;  bus15.SRC_READY = ready;
      bus.SRC_MASK = mask;    bus15.SRC_MASK = mask;
   endtask

   task automatic end_access();
      bus.IO_E = 1'b0;
      bus15.IO_E = 1'b0;
      cpu_pos(); cpu_neg();
      cpu_pos(); cpu_neg();
   endtask

   // IO access with IO_WAIT=1: RDY low at N1 and N2, high at N3
   task automatic io_wait1_access(input string tag);
      cpu_pos();
      check({tag, "_p1"}, bus.RDY, 1'b1);
      cpu_neg();
      check({tag, "_n1"}, bus.RDY, 1'b0);
      cpu_pos(); cpu_neg();
      check({tag, "_n2"}, bus.RDY, 1'b0);
      cpu_pos(); cpu_neg();
      check({tag, "_n3"}, bus.RDY, 1'b1);
      check({tag, "_err"}, bus.TIMEOUT_ERR, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int rise_at;
      drive(1'b0, 1'b0, 1'b1, 3'b111, 3'b111);
      @(negedge clock);
      tick(1'b1, 1'b1);
      check("reset_rdy", bus.RDY, 1'b0);
      check("reset_err", bus.TIMEOUT_ERR, 1'b0);
      reset = 1'b0;

      cpu_neg();
      check("post_reset_neg0", bus.RDY, 1'b0);
      cpu_pos();
      check("post_reset_pos", bus.RDY, 1'b0);
      cpu_neg();
      check("post_reset_neg1", bus.RDY, 1'b1);

      // Basic IO access, all sources ready
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b111);
      io_wait1_access("io_wait1");
      end_access();
      check("io_idle_rdy", bus.RDY, 1'b1);

      // Memory access, source 1 not ready for three CPU clocks
      drive(1'b1, 1'b0, 1'b1, 3'b101, 3'b111);
      cpu_pos(); cpu_neg();
      check("mem_hold_n1", bus.RDY, 1'b0);
      cpu_pos(); cpu_neg();
      cpu_pos(); cpu_neg();
      check("mem_hold_n3", bus.RDY, 1'b0);
      bus.SRC_READY = 3'b111;
      bus15.SRC_READY = 3'b111;
      cpu_pos();
      check("mem_pos_sampled", bus.RDY, 1'b0);
      cpu_neg();
      check("mem_ready_rise", bus.RDY, 1'b1);
      end_access();

      // Masked-off source never delays; an empty mask is always ready
      drive(1'b1, 1'b1, 1'b1, 3'b101, 3'b101);
      io_wait1_access("mask101");
      end_access();
      drive(1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
      io_wait1_access("mask000");
      end_access();

      // Interrupt acknowledge bypasses even the longest wait
      drive(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
      cpu_pos(); cpu_neg();
      check("inta_n1_w15", bus15.RDY, 1'b1);
      check("inta_n1_w1", bus.RDY, 1'b1);
      cpu_pos(); cpu_neg();
      check("inta_n2_w15", bus15.RDY, 1'b1);
      bus.INTA_N = 1'b1;
      bus15.INTA_N = 1'b1;
      cpu_pos(); cpu_neg();
      check("inta_release_w15", bus15.RDY, 1'b0);
      check("inta_release_w1", bus.RDY, 1'b1);
      end_access();

      // Maximum wait count: 16 CPU clocks low, rises at N17
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b111);
      rise_at = 0;
      for (int k = 1; k <= 30 && rise_at == 0; k++) begin
         cpu_pos(); cpu_neg();
         if (bus15.RDY === 1'b1) rise_at = k;
      end
      check_int("io_wait15_rise", rise_at, 17);
      check("io_wait15_main_done", bus.RDY, 1'b1);
      end_access();

      // Both strobes in one clock: negedge sees the freshly updated state and Q
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b111);
      tick(1'b1, 1'b1); tick(1'b0, 1'b0);
      check("both_strobe_1", bus.RDY, 1'b0);
      tick(1'b1, 1'b1); tick(1'b0, 1'b0);
      check("both_strobe_2", bus.RDY, 1'b0);
      tick(1'b1, 1'b1); tick(1'b0, 1'b0);
      check("both_strobe_3", bus.RDY, 1'b1);
      end_access();

      // No source ready: waits forever, or watchdog fires after 4 posedges
      drive(1'b1, 1'b0, 1'b1, 3'b000, 3'b111);
      cpu_pos(); cpu_neg();
      check("hold_rdy_low", bus.RDY, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cpu_pos(); cpu_neg();
      end
      check("hold_err_before", bus.TIMEOUT_ERR, 1'b0);
      cpu_pos();
      check("hold_err_at_limit", bus.TIMEOUT_ERR, EXP_TO);
      cpu_neg();
      check("hold_rdy_at_limit", bus.RDY, EXP_TO);
      bus.IO_E = 1'b0;
      bus15.IO_E = 1'b0;
      cpu_pos();
      check("err_clear_idle", bus.TIMEOUT_ERR, 1'b0);
      cpu_neg();
      check("abort_rdy", bus.RDY, EXP_TO);
      cpu_pos(); cpu_neg();
      check("abort_idle_rdy", bus.RDY, 1'b1);

      // Reset in the middle of a counted access, then a fresh access
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b111);
      cpu_pos(); cpu_neg();
      reset = 1'b1;
      tick(1'b0, 1'b0);
      check("mid_reset_rdy", bus.RDY, 1'b0);
      check("mid_reset_err", bus.TIMEOUT_ERR, 1'b0);
      reset = 1'b0;
      bus.IO_E = 1'b0;
      bus15.IO_E = 1'b0;
      cpu_neg();
      check("after_reset_neg0", bus.RDY, 1'b0);
      cpu_pos(); cpu_neg();
      check("after_reset_neg1", bus.RDY, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 3'b111, 3'b111);
      io_wait1_access("fresh");
      end_access();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
